// File: rtl/wb_arbiter_pkg.sv
// Shared widths and enums for the writeback arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int CNT_W_DEFAULT = 2;
  localparam int NUM_REGS      = 1 << REG_ADDR_W;

  // Which requester won the most recent accepted transfer; reset value LSU makes the first tie go to ALU.
  typedef enum logic {
    SEL_LSU = 1'b0,
    SEL_ALU = 1'b1
  } sel_e;

endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// Per-register in-flight write counters: issue stall, read-after-write hazard, and sticky underflow error.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid_i,
  input  logic                  issue_wena_i,
  input  logic [REG_ADDR_W-1:0] issue_waddr_i,
  input  logic                  commit_valid_i,
  input  logic                  commit_wena_i,
  input  logic [REG_ADDR_W-1:0] commit_waddr_i,
  input  logic                  rena1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  rena2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic                  issue_full_o,
  output logic                  raw_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q, err_d;

  logic             issue_full;
  logic             issue_inc;
  logic             commit_dec;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic             raw1, raw2;

  assign issue_full   = issue_valid_i && issue_wena_i && (cnt_q[issue_waddr_i] == CNT_MAX);
  assign issue_inc    = issue_valid_i && issue_wena_i && (issue_waddr_i != '0) && !issue_full;
  assign commit_dec   = commit_valid_i && commit_wena_i && (commit_waddr_i != '0);
  assign issue_full_o = issue_full;

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    // Entry 0 is never touched, so x0 stays at zero forever.
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_inc && (issue_waddr_i == REG_ADDR_W'(r)) &&
          !(commit_dec && (commit_waddr_i == REG_ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (commit_dec && (commit_waddr_i == REG_ADDR_W'(r)) &&
                   !(issue_inc && (issue_waddr_i == REG_ADDR_W'(r)))) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // A source whose last pending write is committing right now is already resolved.
  assign cnt1 = cnt_q[raddr1_i];
  assign cnt2 = cnt_q[raddr2_i];
  assign raw1 = rena1_i && (raddr1_i != '0) && (cnt1 != '0) &&
                !(commit_valid_i && commit_wena_i && (commit_waddr_i == raddr1_i) && (cnt1 == CNT_ONE));
  assign raw2 = rena2_i && (raddr2_i != '0) && (cnt2 != '0) &&
                !(commit_valid_i && commit_wena_i && (commit_waddr_i == raddr2_i) && (cnt2 == CNT_ONE));
  assign raw_o = raw1 || raw2;
  assign err_o = err_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-way round-robin writeback arbiter (ALU/LSU) feeding one registered regfile write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic                  alu_wena_i,
  input  logic [REG_ADDR_W-1:0] alu_waddr_i,
  input  logic [XLEN-1:0]       alu_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic                  lsu_wena_i,
  input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]       lsu_wdata_i,
  output logic                  commit_valid_o,
  output logic                  commit_wena_o,
  output logic [REG_ADDR_W-1:0] commit_waddr_o,
  output logic [XLEN-1:0]       commit_wdata_o,
  input  logic                  issue_valid_i,
  input  logic                  issue_wena_i,
  input  logic [REG_ADDR_W-1:0] issue_waddr_i,
  output logic                  issue_full_o,
  input  logic                  rena1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  rena2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic                  raw_o,
  output logic                  err_o
);

  sel_e                  last_grant_q, last_grant_d;
  logic                  commit_valid_q, commit_valid_d;
  logic                  commit_wena_q, commit_wena_d;
  logic [REG_ADDR_W-1:0] commit_waddr_q, commit_waddr_d;
  logic [XLEN-1:0]       commit_wdata_q, commit_wdata_d;
  logic                  grant_alu, grant_lsu;
  logic                  xfer_alu, xfer_lsu;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!reset) begin
      if (alu_valid_i && lsu_valid_i) begin
        grant_alu = (last_grant_q != SEL_ALU);
        grant_lsu = (last_grant_q == SEL_ALU);
      end else begin
        grant_alu = alu_valid_i;
        grant_lsu = lsu_valid_i;
      end
    end
  end

  assign alu_ready_o = grant_alu;
  assign lsu_ready_o = grant_lsu;
  assign xfer_alu    = alu_valid_i && alu_ready_o;
  assign xfer_lsu    = lsu_valid_i && lsu_ready_o;

  always_comb begin
    last_grant_d   = last_grant_q;
    commit_valid_d = 1'b0;
    commit_wena_d  = commit_wena_q;
    commit_waddr_d = commit_waddr_q;
    commit_wdata_d = commit_wdata_q;
    if (xfer_alu) begin
      last_grant_d   = SEL_ALU;
      commit_valid_d = 1'b1;
      commit_wena_d  = alu_wena_i;
      commit_waddr_d = alu_waddr_i;
      commit_wdata_d = alu_wdata_i;
    end else if (xfer_lsu) begin
      last_grant_d   = SEL_LSU;
      commit_valid_d = 1'b1;
      commit_wena_d  = lsu_wena_i;
      commit_waddr_d = lsu_waddr_i;
      commit_wdata_d = lsu_wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q   <= SEL_LSU;
      commit_valid_q <= 1'b0;
      commit_wena_q  <= 1'b0;
      commit_waddr_q <= '0;
      commit_wdata_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      commit_valid_q <= commit_valid_d;
      commit_wena_q  <= commit_wena_d;
      commit_waddr_q <= commit_waddr_d;
      commit_wdata_q <= commit_wdata_d;
    end
  end

  assign commit_valid_o = commit_valid_q;
  assign commit_wena_o  = commit_wena_q;
  assign commit_waddr_o = commit_waddr_q;
  assign commit_wdata_o = commit_wdata_q;

  wb_scoreboard #(
    .CNT_W(CNT_W)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .issue_valid_i  (issue_valid_i),
    .issue_wena_i   (issue_wena_i),
    .issue_waddr_i  (issue_waddr_i),
    .commit_valid_i (commit_valid_q),
    .commit_wena_i  (commit_wena_q),
    .commit_waddr_i (commit_waddr_q),
    .rena1_i        (rena1_i),
    .raddr1_i       (raddr1_i),
    .rena2_i        (rena2_i),
    .raddr2_i       (raddr2_i),
    .issue_full_o   (issue_full_o),
    .raw_o          (raw_o),
    .err_o          (err_o)
  );

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter CNT_W, default 2, width of per-register in-flight write counter.
REQ-002 clock  in  1  system clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_valid_i / alu_ready_o  in/out  1/1  ALU writeback handshake.
REQ-005 alu_wena_i, alu_waddr_i, alu_wdata_i  in  1, 5, 32  ALU write enable, destination, data.
REQ-006 lsu_valid_i / lsu_ready_o  in/out  1/1  LSU writeback handshake.
REQ-007 lsu_wena_i, lsu_waddr_i, lsu_wdata_i  in  1, 5, 32  LSU write enable, destination, data.
REQ-008 commit_valid_o, commit_wena_o, commit_waddr_o, commit_wdata_o  out  1, 1, 5, 32  registered single write port toward regfile.
REQ-009 issue_valid_i, issue_wena_i, issue_waddr_i  in  1, 1, 5  decode-issued instruction destination.
REQ-010 issue_full_o  out  1  issue must stall: destination counter saturated.
REQ-011 rena1_i, raddr1_i, rena2_i, raddr2_i  in  1, 5, 1, 5  decode source queries.
REQ-012 raw_o  out  1  read-after-write hazard on either source.
REQ-013 err_o  out  1  sticky: commit seen for register with zero pending count.

Function
REQ-014 Requesters SHALL be granted by 2-way round-robin; last_grant bit flips only on an accepted transfer.
REQ-015 Single valid requester SHALL be granted regardless of last_grant; both valid -> grant the one not granted last.
REQ-016 ready_o SHALL be combinational, high only for the granted requester; transfer = valid && ready.
REQ-017 Accepted transfer SHALL appear on commit_* exactly 1 cycle later as a 1-cycle commit_valid_o pulse; no transfer -> commit_valid_o low.
REQ-018 Sustained throughput SHALL be one transfer per cycle; the regfile port never back-pressures.
REQ-019 Requester payload SHALL be held stable while valid && !ready; arbiter does not check it.
REQ-020 Counter cnt[r] SHALL increment on issue_valid_i && issue_wena_i && issue_waddr_i!=0 && !issue_full_o.
REQ-021 cnt[r] SHALL decrement on commit_valid_o && commit_wena_o && commit_waddr_o==r, r!=0.
REQ-022 Simultaneous increment and decrement of same r SHALL leave cnt[r] unchanged.
REQ-023 Decrement at cnt[r]==0 SHALL leave 0 and set err_o until reset.
REQ-024 issue_full_o SHALL be high when issue_valid_i && issue_wena_i && cnt[issue_waddr_i]==2^CNT_W-1.
REQ-025 raw for source k SHALL = rena_k && cnt[raddr_k]!=0 && !(commit_valid_o && commit_wena_o && commit_waddr_o==raddr_k && cnt[raddr_k]==1).
REQ-026 Register x0 SHALL never be counted; queries of x0 never raise raw_o.
REQ-027 raw_o = raw1 || raw2, combinational from current counters and commit_* registers.

Reset
REQ-028 Reset SHALL clear all cnt[], last_grant (next tie -> ALU), err_o, and commit_valid_o to 0 the following cycle.
REQ-029 Reset mid-operation SHALL drop any registered commit; ready_o is low while reset is high.
REQ-030 commit_wena_o, commit_waddr_o, commit_wdata_o SHALL reset to 0.

Structure
REQ-031 Shared package SHALL hold REG_ADDR_W=5, XLEN=32, and the default CNT_W.
REQ-032 Counter array, raw, full, and err logic SHALL form one sub-module, wb_scoreboard; arbitration and the output register stay in the top level.

Verification
REQ-033 ALU alone valid, waddr=5, wdata=0xDEADBEEF -> alu_ready_o=1 same cycle; commit_valid_o=1, waddr=5, wdata=0xDEADBEEF next cycle.
REQ-034 Both valid 4 cycles after reset -> grants ALU, LSU, ALU, LSU; commit stream alternates.
REQ-035 Issue x7 three times, CNT_W=2 -> cnt=3; fourth issue to x7 -> issue_full_o=1 and count stays 3.
REQ-036 cnt[x3]=1, commit to x3 this cycle, raddr1_i=3 -> raw_o=0; with cnt[x3]=2 -> raw_o=1.
REQ-037 Issue and commit to x9 in same cycle, cnt=1 -> cnt stays 1; commit to x4 with cnt=0 -> err_o=1 and stays 1.
REQ-038 Reset asserted with a transfer in flight -> commit_valid_o=0 next cycle; all counters 0; raw_o=0.
